reg_dump_unit: RTL and testbench
================================

# reg_dump_unit

Debug read-out engine for the pipelined MIPS core's register file. On a start pulse it walks the register file's read port over registers FIRST_REG..NUM_REGS-1 and streams each word out on a valid/ready interface. It holds the pipeline so the snapshot is coherent. It sits beside the register file, sharing one read-address mux with the decode stage, and is driven by the debug/test harness.

## Interface
- NUM_REGS, 32: number of architectural registers.
- ADDR_W, 5: register index width; NUM_REGS ≤ 2^ADDR_W.
- DATA_W, 32: register data width.
- FIRST_REG, 0: first index dumped; must be < NUM_REGS.

- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a dump. Ignored unless IDLE.
- abort  in  1  cancel an active dump. Ignored in IDLE.
- rd_addr  out  ADDR_W  register-file read address. Registered.
- rd_data  in  DATA_W  combinational read data for rd_addr.
- hold_pipeline  out  1  stall request to the pipeline. Registered.
- out_valid  out  1  out_data/out_index/out_last are valid.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- out_data  out  DATA_W  captured register value.
- out_index  out  ADDR_W  register index of out_data.
- out_last  out  1  beat carries index NUM_REGS-1.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, READ, SEND, DONE.
- IDLE, start=1: next state is READ; rd_addr ← FIRST_REG; hold_pipeline ← 1.
- READ (exactly one cycle): at the clock edge, out_data ← rd_data, out_index ← rd_addr, out_last ← (rd_addr == NUM_REGS-1), out_valid ← 1. Next state is SEND.
- SEND: out_valid, out_data, out_index and out_last are held stable until the handshake.
- SEND, on handshake with out_last=0: out_valid ← 0; rd_addr ← rd_addr+1; next state is READ.
- SEND, on handshake with out_last=1: out_valid ← 0; next state is DONE.
- DONE (one cycle): done=1; hold_pipeline ← 0; next state is IDLE.
- abort=1 in READ, SEND or DONE: next state is IDLE. out_valid ← 0 even mid-handshake; any beat accepted in that same cycle counts as delivered. hold_pipeline ← 0, no done pulse, rd_addr ← 0.
- Index arithmetic is unsigned ADDR_W. rd_addr never advances past NUM_REGS-1 and never wraps.
- rd_addr is only meaningful while busy. In IDLE it is 0 and the external mux selects the decode stage.
- Register 0 is streamed like any other index; its value is whatever the register file returns (0 in the MIPS file).
- start while busy: ignored, no restart.
- start and abort together in IDLE: start wins.
- reset overrides everything, including mid-dump. All outputs return to reset values on the next edge.

## Timing
- Reset values: rd_addr=0, hold_pipeline=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0. State is IDLE.
- start sampled at edge k: busy and hold_pipeline are high from cycle k+1, with rd_addr=FIRST_REG.
- A register-file write committed at edge k is visible in the dump. The pipeline must honour hold_pipeline from cycle k+1.
- First out_valid is in cycle k+2.
- Per word: 2 cycles minimum (READ + SEND with out_ready=1).
- Full dump with FIRST_REG=0, NUM_REGS=32 and out_ready tied high: 64 cycles from cycle k+1, then 1 DONE cycle. done is high in cycle k+65; busy is low from cycle k+66.
- out_valid is never high in consecutive READ cycles; there is no back-to-back streaming.
- done and out_valid are never high in the same cycle.

## Test plan
- Preload register i with 0xA000_0000+i (register 0 reads 0). Pulse start with out_ready=1 → 32 beats with out_index 0..31 and out_data matching; out_last only on index 31; done in cycle k+65.
- Same dump with out_ready toggling 1,0,0,1… → each beat held stable while out_ready=0; no beat dropped or duplicated; final order and data identical.
- FIRST_REG=29 → exactly 3 beats (indices 29, 30, 31) with out_last on 31; done 7 cycles after start.
- Assert abort in SEND at index 7 with out_ready=0 → out_valid=0 and busy=0 next cycle; hold_pipeline drops; no done pulse; a new start then dumps from index 0 correctly.
- Assert reset mid-dump at index 12 → all outputs at reset values next cycle. start pulses while busy, and start+abort in IDLE, follow the priority rules above.
- Write 0x1234_5678 to register 5 at the same edge start is sampled → the beat for index 5 carries 0x1234_5678.

Source files
------------

// File: rtl/reg_dump_unit.sv
// reg_dump_unit
// Debug read-out engine for the register file of the pipelined MIPS core.
// A start pulse makes it step the register-file read port over registers
// FIRST_REG..NUM_REGS-1. Each word goes out on a valid/ready stream, and the
// pipeline is held so that the snapshot stays coherent.
//
// Ports
//   i_clock          single clock, all state changes on posedge
//   i_reset          synchronous, active-high reset
//   i_start          one-cycle dump request (acted on only in IDLE)
//   i_abort          cancel an active dump (ignored in IDLE; start wins there)
//   o_rd_addr        register-file read address (registered, 0 when idle)
//   i_rd_data        combinational register-file read data for o_rd_addr
//   o_hold_pipeline  registered stall request to the pipeline
//   o_out_valid      o_out_data / o_out_index / o_out_last are valid
//   i_out_ready      consumer accepts the beat when valid && ready
//   o_out_data       captured register value
//   o_out_index      register index of o_out_data
//   o_out_last       beat carries index NUM_REGS-1
//   o_busy           high in any state other than IDLE
//   o_done           one-cycle pulse on normal completion
module reg_dump_unit #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_hold_pipeline,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_index,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LP_FIRST = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] w_rd_addr_next;
  logic              r_hold;
  logic              w_hold_next;
  logic              r_out_valid;
  logic              w_out_valid_next;
  logic [DATA_W-1:0] r_out_data;
  logic [DATA_W-1:0] w_out_data_next;
  logic [ADDR_W-1:0] r_out_index;
  logic [ADDR_W-1:0] w_out_index_next;
  logic              r_out_last;
  logic              w_out_last_next;
  logic              w_handshake;

  assign w_handshake = r_out_valid & i_out_ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rd_addr   <= '0;
      r_hold      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_rd_addr   <= w_rd_addr_next;
      r_hold      <= w_hold_next;
      r_out_valid <= w_out_valid_next;
      r_out_data  <= w_out_data_next;
      r_out_index <= w_out_index_next;
      r_out_last  <= w_out_last_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_rd_addr_next   = r_rd_addr;
    w_hold_next      = r_hold;
    w_out_valid_next = r_out_valid;
    w_out_data_next  = r_out_data;
    w_out_index_next = r_out_index;
    w_out_last_next  = r_out_last;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next   = S_READ;
          w_rd_addr_next = LP_FIRST;
          w_hold_next    = 1'b1;
        end
      end
      S_READ: begin
        w_out_data_next  = i_rd_data;
        w_out_index_next = r_rd_addr;
        w_out_last_next  = (r_rd_addr == LP_LAST);
        w_out_valid_next = 1'b1;
        w_state_next     = S_SEND;
      end
      S_SEND: begin
        if (w_handshake) begin
          w_out_valid_next = 1'b0;
          // The last beat moves on to DONE and leaves the address alone,
          // so rd_addr never goes past NUM_REGS-1.
          if (r_out_last) begin
            w_state_next = S_DONE;
          end else begin
            w_rd_addr_next = r_rd_addr + ADDR_W'(1);
            w_state_next   = S_READ;
          end
        end
      end
      S_DONE: begin
        w_hold_next    = 1'b0;
        w_rd_addr_next = '0;
        w_state_next   = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort overrides every active state. A beat that handshakes in the
    // same cycle has already reached the consumer, so only valid is dropped.
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_next     = S_IDLE;
      w_out_valid_next = 1'b0;
      w_hold_next      = 1'b0;
      w_rd_addr_next   = '0;
    end
  end

  assign o_rd_addr       = r_rd_addr;
  assign o_hold_pipeline = r_hold;
  assign o_out_valid     = r_out_valid;
  assign o_out_data      = r_out_data;
  assign o_out_index     = r_out_index;
  assign o_out_last      = r_out_last;
  assign o_busy          = (r_state != S_IDLE);
  // An abort in the DONE cycle cancels completion, so done is masked there.
  assign o_done          = (r_state == S_DONE) && !i_abort;

endmodule

// File: tb/tb_reg_dump_unit.sv
// tb_reg_dump_unit
// Directed bench for reg_dump_unit. It has two instances: one with
// FIRST_REG=0 and one with FIRST_REG=29. Both share a small register-file
// model. Inputs are driven and outputs sampled on the falling clock edge.
module tb_reg_dump_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        abort;
  logic        ready;
  logic        start29;
  logic        abort29;
  logic        ready29;

  logic [4:0]  addr0;
  logic [31:0] rd0;
  logic        hold0;
  logic        valid0;
  logic [31:0] data0;
  logic [4:0]  idx0;
  logic        last0;
  logic        busy0;
  logic        done0;

  logic [4:0]  addr29;
  logic [31:0] rd29;
  logic        hold29;
  logic        valid29;
  logic [31:0] data29;
  logic [4:0]  idx29;
  logic        last29;
  logic        busy29;
  logic        done29;

  // Register-file model. Reset preloads 0xA000_0000+i, and register 0 holds 0.
  logic [31:0] rf [32];
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : (32'hA000_0000 + 32'(i));
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  assign rd0  = rf[addr0];
  assign rd29 = rf[addr29];

  reg_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(0)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .o_rd_addr(addr0), .i_rd_data(rd0), .o_hold_pipeline(hold0),
    .o_out_valid(valid0), .i_out_ready(ready), .o_out_data(data0),
    .o_out_index(idx0), .o_out_last(last0), .o_busy(busy0), .o_done(done0)
  );

  reg_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(29)) dut29 (
    .i_clock(clk), .i_reset(rst), .i_start(start29), .i_abort(abort29),
    .o_rd_addr(addr29), .i_rd_data(rd29), .o_hold_pipeline(hold29),
    .o_out_valid(valid29), .i_out_ready(ready29), .o_out_data(data29),
    .o_out_index(idx29), .o_out_last(last29), .o_busy(busy29), .o_done(done29)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_word(input int i, input bit mod5);
    if (i == 0) return 32'h0;
    if (mod5 && i == 5) return 32'h1234_5678;
    return 32'hA000_0000 + 32'(i);
  endfunction

  // Full dump on the FIRST_REG=0 instance.
  // mode 0: ready held high.
  // mode 1: ready high one cycle in three.
  // A stray start is pulsed at cycle 10 and must not restart the dump.
  task automatic do_dump(input int mode, input bit with_abort, input bit wr5);
    int cyc;
    int exp_idx;
    int done_cyc;
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    ready = 1'b1;
    if (wr5) begin
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'h1234_5678;
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    wr_en = 1'b0;
    cyc   = 1;
    chk("start_busy", 64'(busy0), 64'(1));
    chk("start_hold", 64'(hold0), 64'(1));
    chk("start_addr", 64'(addr0), 64'(0));
    chk("start_valid", 64'(valid0), 64'(0));
    exp_idx  = 0;
    done_cyc = 0;
    while (cyc < 400 && done_cyc == 0) begin
      ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      start = (cyc == 10);
      if (valid0) begin
        chk($sformatf("beat_index[%0d]", exp_idx), 64'(idx0), 64'(exp_idx));
        chk($sformatf("beat_data[%0d]", exp_idx), 64'(data0), 64'(exp_word(exp_idx, wr5)));
        chk($sformatf("beat_last[%0d]", exp_idx), 64'(last0), 64'(exp_idx == 31));
        if (ready) exp_idx++;
      end
      if (done0) begin
        done_cyc = cyc;
        chk("done_no_valid", 64'(valid0), 64'(0));
        chk("done_hold", 64'(hold0), 64'(1));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    chk("beat_count", 64'(exp_idx), 64'(32));
    chk("done_seen", 64'(done_cyc != 0), 64'(1));
    if (mode == 0) chk("done_cycle", 64'(done_cyc), 64'(65));
    chk("post_busy", 64'(busy0), 64'(0));
    chk("post_done", 64'(done0), 64'(0));
    chk("post_hold", 64'(hold0), 64'(0));
    chk("post_addr", 64'(addr0), 64'(0));
  endtask

  initial begin
    int cyc;
    int exp_idx;
    int done_cyc;
    int n;

    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    ready   = 1'b1;
    start29 = 1'b0;
    abort29 = 1'b0;
    ready29 = 1'b1;
    wr_en   = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state.
    chk("rst_addr",  64'(addr0),  64'(0));
    chk("rst_hold",  64'(hold0),  64'(0));
    chk("rst_valid", 64'(valid0), 64'(0));
    chk("rst_data",  64'(data0),  64'(0));
    chk("rst_index", 64'(idx0),   64'(0));
    chk("rst_last",  64'(last0),  64'(0));
    chk("rst_busy",  64'(busy0),  64'(0));
    chk("rst_done",  64'(done0),  64'(0));
    chk("rst_busy29", 64'(busy29), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Full dump with ready held high, then with a throttled ready.
    do_dump(0, 1'b0, 1'b0);
    do_dump(1, 1'b0, 1'b0);

    // FIRST_REG=29 instance: three beats, done 7 cycles after start.
    @(negedge clk);
    start29 = 1'b1;
    @(negedge clk);
    start29  = 1'b0;
    cyc      = 1;
    exp_idx  = 29;
    done_cyc = 0;
    while (cyc < 50 && done_cyc == 0) begin
      if (valid29) begin
        chk($sformatf("f29_index[%0d]", exp_idx), 64'(idx29), 64'(exp_idx));
        chk($sformatf("f29_data[%0d]", exp_idx), 64'(data29), 64'(exp_word(exp_idx, 1'b0)));
        chk($sformatf("f29_last[%0d]", exp_idx), 64'(last29), 64'(exp_idx == 31));
        exp_idx++;
      end
      if (done29) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    chk("f29_end_index", 64'(exp_idx), 64'(32));
    chk("f29_done_cycle", 64'(done_cyc), 64'(7));
    chk("f29_post_busy", 64'(busy29), 64'(0));
    chk("f29_post_hold", 64'(hold29), 64'(0));

    // Abort in SEND at index 7 while ready is low.
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 100 && !(valid0 && idx0 == 5'd7)) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_idx7", 64'(idx0), 64'(7));
    ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ready = 1'b1;
    chk("abort_valid", 64'(valid0), 64'(0));
    chk("abort_busy",  64'(busy0),  64'(0));
    chk("abort_hold",  64'(hold0),  64'(0));
    chk("abort_done",  64'(done0),  64'(0));
    chk("abort_addr",  64'(addr0),  64'(0));
    @(negedge clk);
    chk("abort_no_done_later", 64'(done0), 64'(0));
    chk("abort_stays_idle", 64'(busy0), 64'(0));
    // A new dump after the abort starts again from index 0.
    do_dump(0, 1'b0, 1'b0);

    // Reset mid-dump at index 12.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (n < 100 && !(valid0 && idx0 == 5'd12)) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_reach_idx12", 64'(idx0), 64'(12));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_addr",  64'(addr0),  64'(0));
    chk("mid_rst_hold",  64'(hold0),  64'(0));
    chk("mid_rst_valid", 64'(valid0), 64'(0));
    chk("mid_rst_data",  64'(data0),  64'(0));
    chk("mid_rst_index", 64'(idx0),   64'(0));
    chk("mid_rst_last",  64'(last0),  64'(0));
    chk("mid_rst_busy",  64'(busy0),  64'(0));
    chk("mid_rst_done",  64'(done0),  64'(0));

    // start and abort together in IDLE: start wins, full dump follows.
    do_dump(0, 1'b1, 1'b0);

    // Register 5 written at the edge that samples start: the dump sees the new value.
    do_dump(0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
